// File: rtl/frame_stage_buffer.sv
// Circular sample buffer that streams one FRAME_LEN frame per send order to the receive unit.
// Optional saturating dropped-write counter: define DROP_CNT_EN to add drop_clr_i / drop_cnt_o.
module frame_stage_buffer #(
  parameter int DATA_W    = 25,
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = 7,
  parameter int FRAME_LEN = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              send_en_i,
  output logic [DATA_W-1:0] buf_out_o,
  output logic              buf_valid_o,
  output logic              frame_done_o,
  output logic              frame_avail_o,
  output logic              underrun_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
`ifdef DROP_CNT_EN
  input  logic              drop_clr_i,
  output logic [7:0]        drop_cnt_o,
`endif
  output logic [ADDR_W-1:0] wr_addr_o
);

  // state  | meaning
  // S_IDLE | waiting for send_en_i with a full frame stored
  // S_SEND | frame in progress; send_en_i low pauses it
  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] FRAME_LEN_C = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] LAST_IDX   = (ADDR_W+1)'(FRAME_LEN - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     sent_cnt_q, sent_cnt_d;
  logic [DATA_W-1:0]   buf_out_q;
  logic                buf_valid_q, frame_done_q, underrun_q;
  logic                rd_en, wr_en, last_smp, underrun_d, frame_done_d;

  assign full_o        = (count_q == DEPTH_C);
  assign empty_o       = (count_q == '0);
  assign frame_avail_o = (count_q >= FRAME_LEN_C);
  assign wr_ready_o    = !full_o;
  assign count_o       = count_q;
  assign wr_addr_o     = wr_ptr_q;
  assign buf_out_o     = buf_out_q;
  assign buf_valid_o   = buf_valid_q;
  assign frame_done_o  = frame_done_q;
  assign underrun_o    = underrun_q;

  assign wr_en = wr_valid_i && !full_o;
  // sent_cnt_q is zero in IDLE, so a one-sample frame finishes on its entry edge
  assign last_smp = (sent_cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (send_en_i && frame_avail_o && !last_smp) state_d = S_SEND;
      S_SEND:  if (send_en_i && last_smp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en      = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        rd_en      = send_en_i && frame_avail_o;
        underrun_d = send_en_i && !frame_avail_o;
      end
      S_SEND:  rd_en = send_en_i;
      default: ;
    endcase
    frame_done_d = rd_en && last_smp;
    sent_cnt_d   = sent_cnt_q;
    if (rd_en) sent_cnt_d = last_smp ? '0 : sent_cnt_q + 1'b1;
    count_d = count_q + {{ADDR_W{1'b0}}, wr_en} - {{ADDR_W{1'b0}}, rd_en};
  end

  // Storage is not reset; contents are meaningless until rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sent_cnt_q   <= '0;
      buf_out_q    <= '0;
      buf_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      sent_cnt_q   <= sent_cnt_d;
      buf_valid_q  <= rd_en;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) begin
        buf_out_q <= mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

`ifdef DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      drop_cnt_q <= '0;
    else if (drop_clr_i)                             drop_cnt_q <= '0;
    else if (wr_valid_i && full_o && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_frame_stage_buffer.sv
// Bench for frame_stage_buffer: queue-based reference model, randomized data and control.
module tb_frame_stage_buffer;
  localparam int DW = 25;
  localparam int FL = 50;
  localparam int DP = 128;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          wr_valid = 0;
  logic [DW-1:0] wr_data = '0;
  logic          send_en = 0;
  logic          drop_clr = 0;
  logic          wr_ready, buf_valid, frame_done, frame_avail, underrun, full, empty;
  logic [DW-1:0] buf_out;
  logic [7:0]    count;
  logic [6:0]    wr_addr;
`ifdef DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  frame_stage_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .send_en_i(send_en), .buf_out_o(buf_out), .buf_valid_o(buf_valid),
    .frame_done_o(frame_done), .frame_avail_o(frame_avail), .underrun_o(underrun),
    .full_o(full), .empty_o(empty), .count_o(count),
`ifdef DROP_CNT_EN
    .drop_clr_i(drop_clr), .drop_cnt_o(drop_cnt),
`endif
    .wr_addr_o(wr_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: stored samples in arrival order plus frame progress
  logic [DW-1:0] q[$];
  bit            m_sending;
  int            m_sent, m_wptr, m_drops;
  logic [DW-1:0] e_out;
  bit            e_valid, e_done, e_under;

  task automatic model_reset();
    q.delete();
    m_sending = 0; m_sent = 0; m_wptr = 0; m_drops = 0;
    e_out = '0; e_valid = 0; e_done = 0; e_under = 0;
  endtask

  // Apply current inputs to the model, then let the DUT take the same edge.
  task automatic tick();
    bit full_b;
    bit rd;
    full_b  = (q.size() == DP);
    e_done  = 0;
    e_under = !m_sending && send_en && (q.size() < FL);
    rd      = send_en && (m_sending || q.size() >= FL);
    e_valid = rd;
    if (rd) begin
      e_out = q.pop_front();
      m_sent++;
      if (m_sent == FL) begin e_done = 1; m_sending = 0; m_sent = 0; end
      else m_sending = 1;
    end
    if (wr_valid && !full_b) begin q.push_back(wr_data); m_wptr = (m_wptr + 1) % DP; end
    if (drop_clr) m_drops = 0;
    else if (wr_valid && full_b && m_drops < 255) m_drops++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    wr_valid = 0; send_en = 0; drop_clr = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic write_n(int n, bit seq, int base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1;
      wr_data  = seq ? DW'(base + i) : DW'($urandom);
      tick();
    end
    wr_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (count !== 8'd0)  begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
    n_cmp++; if (empty !== 1'b1)  begin n_bad++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_cmp++; if (full !== 1'b0 || wr_ready !== 1'b1 || frame_avail !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags full=%b ready=%b avail=%b exp 0 1 0", full, wr_ready, frame_avail); end
    n_cmp++; if (buf_valid !== 1'b0 || buf_out !== '0 || wr_addr !== 7'd0) begin
      n_bad++; $display("FAIL reset_outputs valid=%b out=%0h addr=%0d exp 0 0 0", buf_valid, buf_out, wr_addr); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    write_n(FL, 1, 1);
    n_cmp++; if (count !== 8'd50 || frame_avail !== 1'b1 || empty !== 1'b0) begin
      n_bad++; $display("FAIL basic_status count=%0d avail=%b empty=%b exp 50 1 0", count, frame_avail, empty); end
    send_en = 1;
    for (int i = 1; i <= FL; i++) begin
      if (i == FL) begin tick(); send_en = 0; end
      else tick();
      n_cmp++; if (buf_valid !== 1'b1 || buf_out !== DW'(i)) begin
        n_bad++; $display("FAIL basic_sample%0d valid=%b out=%0d exp 1 %0d", i, buf_valid, buf_out, i); end
      n_cmp++; if (frame_done !== (i == FL)) begin
        n_bad++; $display("FAIL basic_done%0d got %b exp %b", i, frame_done, i == FL); end
    end
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL basic_count_after got %0d exp 0", count); end
    tick();
    n_cmp++; if (buf_valid !== 1'b0 || buf_out !== DW'(FL)) begin
      n_bad++; $display("FAIL basic_idle_hold valid=%b out=%0d exp 0 50", buf_valid, buf_out); end
  endtask

  task automatic test_underrun();
    do_reset();
    write_n(10, 0, 0);
    send_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (underrun !== 1'b1 || buf_valid !== 1'b0 || count !== 8'd10) begin
        n_bad++; $display("FAIL underrun_cyc%0d under=%b valid=%b count=%0d exp 1 0 10", i, underrun, buf_valid, count); end
    end
    send_en = 0;
    tick();
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL underrun_clear got %b exp 0", underrun); end
  endtask

  task automatic test_pause();
    do_reset();
    write_n(FL, 0, 0);
    for (int c = 0; c < 55; c++) begin
      send_en = !(c >= 20 && c < 25);
      tick();
      n_cmp++; if (buf_valid !== e_valid || (e_valid && buf_out !== e_out)) begin
        n_bad++; $display("FAIL pause_c%0d valid=%b out=%0h exp %b %0h", c, buf_valid, buf_out, e_valid, e_out); end
      n_cmp++; if (frame_done !== e_done || (c == 54 && !e_done)) begin
        n_bad++; $display("FAIL pause_done_c%0d got %b exp %b", c, frame_done, e_done); end
    end
    send_en = 0;
  endtask

  task automatic test_full_wrap();
    do_reset();
    write_n(DP, 0, 0);
    n_cmp++; if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 8'd128) begin
      n_bad++; $display("FAIL wrap_full full=%b ready=%b count=%0d exp 1 0 128", full, wr_ready, count); end
    write_n(3, 0, 0);
    n_cmp++; if (count !== 8'd128 || wr_addr !== 7'd0) begin
      n_bad++; $display("FAIL wrap_drop count=%0d addr=%0d exp 128 0", count, wr_addr); end
`ifdef DROP_CNT_EN
    n_cmp++; if (drop_cnt !== 8'd3) begin n_bad++; $display("FAIL wrap_drop_cnt got %0d exp 3", drop_cnt); end
`endif
    send_en = 1;
    for (int i = 0; i < FL; i++) tick();
    send_en = 0;
    n_cmp++; if (count !== 8'd78) begin n_bad++; $display("FAIL wrap_count78 got %0d exp 78", count); end
    write_n(60, 0, 0);
    n_cmp++; if (count !== 8'(q.size()) || wr_addr !== 7'(m_wptr)) begin
      n_bad++; $display("FAIL wrap_refill count=%0d addr=%0d exp %0d %0d", count, wr_addr, q.size(), m_wptr); end
    send_en = 1;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      n_cmp++; if (buf_valid !== e_valid || buf_out !== e_out || frame_done !== e_done) begin
        n_bad++; $display("FAIL wrap_read%0d v=%b o=%0h d=%b exp %b %0h %b", i, buf_valid, buf_out, frame_done, e_valid, e_out, e_done); end
    end
    send_en = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_n(60, 0, 0);
    send_en = 1; wr_valid = 1;
    for (int i = 0; i < FL; i++) begin
      wr_data = DW'($urandom);
      tick();
      n_cmp++; if (count !== 8'd60 || buf_out !== e_out || buf_valid !== 1'b1 || frame_done !== e_done) begin
        n_bad++; $display("FAIL b2b_%0d count=%0d out=%0h v=%b d=%b exp 60 %0h 1 %b", i, count, buf_out, buf_valid, frame_done, e_out, e_done); end
    end
    send_en = 0; wr_valid = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      wr_valid = ($urandom_range(0, 99) < 70);
      wr_data  = DW'($urandom);
      send_en  = ($urandom_range(0, 99) < 45);
      drop_clr = ($urandom_range(0, 99) < 3);
      tick();
      n_cmp++; if (buf_valid !== e_valid || (e_valid && buf_out !== e_out) || frame_done !== e_done || underrun !== e_under) begin
        n_bad++; $display("FAIL rand_c%0d v=%b o=%0h d=%b u=%b exp %b %0h %b %b", c, buf_valid, buf_out, frame_done, underrun, e_valid, e_out, e_done, e_under); end
      n_cmp++; if (count !== 8'(q.size()) || full !== (q.size() == DP) || empty !== (q.size() == 0) ||
                   frame_avail !== (q.size() >= FL) || wr_addr !== 7'(m_wptr)) begin
        n_bad++; $display("FAIL rand_status_c%0d count=%0d addr=%0d exp %0d %0d", c, count, wr_addr, q.size(), m_wptr); end
`ifdef DROP_CNT_EN
      n_cmp++; if (drop_cnt !== 8'(m_drops)) begin n_bad++; $display("FAIL rand_drops_c%0d got %0d exp %0d", c, drop_cnt, m_drops); end
`endif
    end
    wr_valid = 0; send_en = 0; drop_clr = 0;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    write_n(FL, 0, 0);
    send_en = 1;
    for (int i = 0; i < 25; i++) tick();
    #2 rst_n = 0;
    #1;
    n_cmp++; if (buf_valid !== 1'b0 || buf_out !== '0 || frame_done !== 1'b0 || underrun !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs v=%b o=%0h d=%b u=%b exp 0 0 0 0", buf_valid, buf_out, frame_done, underrun); end
    n_cmp++; if (count !== 8'd0 || empty !== 1'b1 || wr_addr !== 7'd0 || wr_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_status count=%0d empty=%b addr=%0d ready=%b exp 0 1 0 1", count, empty, wr_addr, wr_ready); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (frame_done !== 1'b0 || buf_valid !== 1'b0 || underrun !== 1'b1) begin
        n_bad++; $display("FAIL midrst_after%0d d=%b v=%b u=%b exp 0 0 1", i, frame_done, buf_valid, underrun); end
    end
    send_en = 0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_pause();
    test_full_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/frame_stage_buffer.md
Name: frame_stage_buffer

Overview:
- Circular RAM buffer between the ultrasonic processing pipeline and the receive/send unit.
- Stores processed 25-bit samples as they arrive from the pipeline.
- When the receive unit raises its buffer send enable, the block streams out exactly one frame of FRAME_LEN samples, one per clock, in arrival order.
- It reports fill status so the receive unit can tell when a frame is available and can see underrun and overflow events.

Parameters:
DATA_W, 25, sample width (matches receive-unit FIFO_DATA)
DEPTH, 128, sample storage depth; must be a power of 2
ADDR_W, 7, log2(DEPTH)
FRAME_LEN, 50, samples per frame sent per order; 1 <= FRAME_LEN <= DEPTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  pipeline sample strobe
wr_data  in  DATA_W  pipeline sample
wr_ready  out  1  buffer can accept a write (= !full)
send_en  in  1  send enable from receive unit (its send_enB); level-sensitive
buf_out  out  DATA_W  sample to receive unit (its buf_in)
buf_valid  out  1  buf_out holds a valid sample this cycle
frame_done  out  1  one-cycle pulse coincident with the last sample of a frame
frame_avail  out  1  count >= FRAME_LEN
underrun  out  1  one-cycle pulse: send_en in IDLE with frame_avail low
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  ADDR_W+1  samples stored
wr_addr  out  ADDR_W  current write pointer, for debug

Behaviour:
- Reset (async assert, sync release): wr_ptr, rd_ptr, count, sent_cnt = 0; state = IDLE; buf_out = 0; buf_valid, frame_done, underrun = 0; empty = 1; full = 0; frame_avail = 0; wr_ready = 1. Stored data is discarded.
- Storage: DEPTH x DATA_W array. Pointers are ADDR_W wide and wrap modulo DEPTH naturally (127 -> 0).
- Write: on a rising edge with wr_valid && !full, mem[wr_ptr] <= wr_data and wr_ptr increments. A write while full is dropped, with no pointer or count change.
- FSM states: IDLE, SEND.
- IDLE, send_en=1 and frame_avail=1: move to SEND. On that same edge, buf_out <= mem[rd_ptr], buf_valid <= 1, rd_ptr++, sent_cnt <= 1. Latency is one cycle from send_en sampled to first valid sample.
- IDLE, send_en=1 and frame_avail=0: underrun pulses for one cycle and the FSM stays in IDLE. The pulse repeats every cycle send_en stays high without a frame.
- SEND, send_en=1: emit the next sample in the same way and increment sent_cnt. On the edge emitting sample number FRAME_LEN, frame_done <= 1, sent_cnt <= 0 and state <= IDLE.
- SEND, send_en=0: pause. buf_valid <= 0, pointers and sent_cnt hold, and state stays SEND. The frame resumes when send_en returns high.
- In IDLE with no read, buf_valid <= 0 and buf_out holds its last value.
- Count: +1 on an accepted write, -1 on a read, unchanged when both happen on the same edge.
- Simultaneous write and read at the same address cannot occur: a read needs count >= 1.
- Once a frame starts, all FRAME_LEN samples are already stored because frame_avail was checked at entry. SEND therefore never reads an empty buffer.
- Writes continue normally during SEND.
- Status outputs are derived combinationally from registered count.
- Reset during SEND aborts the frame immediately. No frame_done is produced, and the aborted frame is not re-sent.

Optional Feature:
- Macro: DROP_CNT_EN.
- When defined: adds output drop_cnt (8 bits). It is a saturating counter incremented on each edge with wr_valid && full. It stops at 255, is cleared by reset, and is also cleared by a one-cycle input drop_clr (drop_clr wins over a same-cycle increment).
- When undefined: neither port exists and dropped writes are silent.

Test Plan:
- Reset then write 50 samples (values 1..50) -> count=50, frame_avail=1, empty=0; send_en held high -> buf_out 1..50 on 50 consecutive cycles starting one cycle after send_en, frame_done with value 50, count=0.
- Write 10 samples, pulse send_en for 3 cycles -> underrun pulses on each of the 3 cycles, buf_valid never high, count stays 10.
- 50 stored, send_en high 20 cycles, low 5, high again -> samples 1..20, then buf_valid=0 for 5 cycles, then 21..50 with frame_done on 50.
- Write 128 samples -> full=1, wr_ready=0; 3 more writes dropped (drop_cnt=3 with DROP_CNT_EN); send one frame -> count=78. Write 60 more -> wr_addr wraps through 0 and read order stays correct across the wrap.
- During SEND, write one sample on every cycle -> count unchanged while both happen, frame output unaffected.
- Assert rst_n=0 at sample 25 of a frame -> all outputs at reset values immediately, count=0, no frame_done.
